// File: rtl/dcache_core.sv
`timescale 1ns/1ps
// One direct-mapped, write-back way of the data cache: combinational lookup,
// CPU store merge into resident lines, whole-block fill from the parent controller.
module dcache_core #(
  parameter int data = 32,
  parameter int addr = 32,
  parameter int ofst = 5,
  parameter int indx = 9
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    SYS,
  input  logic                    dread,
  input  logic                    dwrite,
  input  logic [1:0]              dwmode,
  output logic                    bread,
  input  logic                    bwrite,
  input  logic [addr-1:0]         address,
  input  logic [data-1:0]         data_in,
  input  logic [(8<<ofst)-1:0]    block_in,
  output logic [(8<<ofst)-1:0]    block_out,
  output logic [data-1:0]         data_out,
  output logic                    hit
);

  localparam int blck  = 8 << ofst;
  localparam int tagw  = addr - indx - ofst;
  localparam int lines = 1 << indx;
  localparam int wsel  = ofst - 2;

  logic [tagw-1:0] tag_s;
  logic [indx-1:0] index_s;
  logic [wsel-1:0] word_s;
  logic [1:0]      lane_s;

  logic            valid_arr_s [lines];
  logic            dirty_arr_s [lines];
  logic [tagw-1:0] tag_arr_s   [lines];
  logic [blck-1:0] line_arr_s  [lines];

  logic [blck-1:0] line_s;
  logic            tag_match_s;
  logic            hit_s;
  logic            fill_en_s;
  logic            store_en_s;
  logic [blck-1:0] store_line_s;
  logic            unused_s;

  // Little-endian lane merge: untouched bytes of the old word survive.
  function automatic logic [31:0] merge_word(
    input logic [31:0] old_w,
    input logic [31:0] wdata,
    input logic [1:0]  mode,
    input logic [1:0]  lane
  );
    logic [31:0] res;
    res = old_w;
    case (mode)
      2'b01:   res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      2'b10:   res[{lane, 3'b000} +: 8]      = wdata[7:0];
      default: res = wdata;
    endcase
    return res;
  endfunction

  assign tag_s   = address[addr-1:indx+ofst];
  assign index_s = address[indx+ofst-1:ofst];
  assign word_s  = address[ofst-1:2];
  assign lane_s  = address[1:0];

  // Loads need no action here; lookup is unconditional.
  assign unused_s = dread;

  assign line_s      = line_arr_s[index_s];
  assign tag_match_s = (tag_arr_s[index_s] == tag_s);
  assign hit_s       = valid_arr_s[index_s] & tag_match_s;

  assign fill_en_s  = ~SYS & bwrite;
  assign store_en_s = ~SYS & ~bwrite & dwrite & hit_s;

  // Build the indexed line with the store word merged in.
  always_comb begin
    store_line_s = line_s;
    store_line_s[word_s*data +: data] =
      merge_word(line_s[word_s*data +: data], data_in, dwmode, lane_s);
  end

  genvar gi;
  generate
    for (gi = 0; gi < lines; gi++) begin : g_line
      localparam int unsigned line_num = gi;
      logic            valid_r;
      logic            dirty_r;
      logic [tagw-1:0] tag_r;
      logic [blck-1:0] data_r;
      logic            sel_s;

      assign sel_s = (index_s == line_num[indx-1:0]);

      // Per-line state: reset clears, fill beats store, store marks dirty.
      always_ff @(posedge CLK) begin
        if (!RESET) begin
          valid_r <= 1'b0;
          dirty_r <= 1'b0;
          tag_r   <= '0;
          data_r  <= '0;
        end else if (fill_en_s && sel_s) begin
          valid_r <= 1'b1;
          dirty_r <= 1'b0;
          tag_r   <= tag_s;
          data_r  <= block_in;
        end else if (store_en_s && sel_s) begin
          dirty_r <= 1'b1;
          data_r  <= store_line_s;
        end
      end

      assign valid_arr_s[gi] = valid_r;
      assign dirty_arr_s[gi] = dirty_r;
      assign tag_arr_s[gi]   = tag_r;
      assign line_arr_s[gi]  = data_r;
    end
  endgenerate

  assign hit       = hit_s;
  assign bread     = valid_arr_s[index_s] & dirty_arr_s[index_s] & ~tag_match_s;
  assign block_out = line_s;
  assign data_out  = line_s[word_s*data +: data];

endmodule

// File: tb/tb_dcache_core.sv
`timescale 1ns/1ps
// Scoreboard bench for dcache_core: byte-level reference model, directed
// walk through the key scenarios, then randomized traffic.
module tb_dcache_core;

  logic         CLK = 1'b0;
  logic         RESET, SYS, dread, dwrite, bwrite;
  logic [1:0]   dwmode;
  logic         bread, hit;
  logic [31:0]  address, data_in, data_out;
  logic [255:0] block_in, block_out;

  always #5 CLK = ~CLK;

  dcache_core dut (
    .CLK(CLK), .RESET(RESET), .SYS(SYS), .dread(dread), .dwrite(dwrite),
    .dwmode(dwmode), .bread(bread), .bwrite(bwrite), .address(address),
    .data_in(data_in), .block_in(block_in), .block_out(block_out),
    .data_out(data_out), .hit(hit)
  );

  typedef struct {
    logic         hit;
    logic         bread;
    logic [31:0]  dout;
    logic [255:0] blk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Reference model: lines kept as byte arrays.
  logic [7:0]  m_data  [512][32];
  bit          m_valid [512];
  bit          m_dirty [512];
  logic [17:0] m_tag   [512];

  function automatic exp_t model_look(input logic [31:0] a);
    exp_t e;
    int   idx, off;
    bit   match;
    idx   = int'(a[13:5]);
    off   = int'(a[4:2]) * 4;
    match = m_valid[idx] && (m_tag[idx] == a[31:14]);
    e.hit   = match;
    e.bread = m_valid[idx] && m_dirty[idx] && !match;
    for (int b = 0; b < 32; b++) e.blk[8*b +: 8] = m_data[idx][b];
    for (int b = 0; b < 4; b++)  e.dout[8*b +: 8] = m_data[idx][off+b];
    return e;
  endfunction

  function automatic void model_update(input logic rst, input logic sys,
                                       input logic dw, input logic bw,
                                       input logic [1:0] mode, input logic [31:0] a,
                                       input logic [31:0] din, input logic [255:0] blk);
    int idx, off, size, start;
    bit match;
    idx   = int'(a[13:5]);
    off   = int'(a[4:0]);
    match = m_valid[idx] && (m_tag[idx] == a[31:14]);
    if (!rst) begin
      for (int i = 0; i < 512; i++) begin
        m_valid[i] = 1'b0;
        m_dirty[i] = 1'b0;
        m_tag[i]   = 18'd0;
        for (int b = 0; b < 32; b++) m_data[i][b] = 8'd0;
      end
    end else if (!sys && bw) begin
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = a[31:14];
      for (int b = 0; b < 32; b++) m_data[idx][b] = blk[8*b +: 8];
    end else if (!sys && dw && match) begin
      size  = (mode == 2'b01) ? 2 : (mode == 2'b10) ? 1 : 4;
      start = off & ~(size - 1);
      for (int i = 0; i < size; i++) m_data[idx][start+i] = din[8*i +: 8];
      m_dirty[idx] = 1'b1;
    end
  endfunction

  function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endfunction

  // Monitor: outputs are combinational, so each cycle has one expectation.
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("hit", {255'd0, hit}, {255'd0, mon_e.hit});
      chk("bread", {255'd0, bread}, {255'd0, mon_e.bread});
      chk("data_out", {224'd0, data_out}, {224'd0, mon_e.dout});
      chk("block_out", block_out, mon_e.blk);
    end
  end

  task automatic cycle(input logic rst, input logic sys, input logic dw, input logic bw,
                       input logic [1:0] mode, input logic [31:0] a, input logic [31:0] din,
                       input logic [255:0] blk, input bit push, input bit ovr,
                       input logic ehit, input logic ebread, input logic [31:0] edout);
    exp_t e;
    RESET = rst; SYS = sys; dwrite = dw; bwrite = bw; dwmode = mode;
    address = a; data_in = din; block_in = blk; dread = ~dw & ~bw;
    e = model_look(a);
    if (ovr) begin
      e.hit = ehit; e.bread = ebread; e.dout = edout;
    end
    if (push) sb.push_back(e);
    @(posedge CLK);
    model_update(rst, sys, dw, bw, mode, a, din, blk);
    #1;
  endtask

  function automatic logic [255:0] mk_blk(input logic [31:0] base);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = base + 32'(k);
    return r;
  endfunction

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 256'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask
  task automatic do_fill(input logic [31:0] a, input logic [255:0] blk);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, a, 32'd0, blk, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask
  task automatic do_store(input logic [31:0] a, input logic [1:0] mode, input logic [31:0] d);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, mode, a, d, 256'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask
  task automatic probe(input logic [31:0] a, input logic h, input logic b, input logic [31:0] d);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, a, 32'd0, 256'd0, 1'b1, 1'b1, h, b, d);
  endtask

  logic [17:0]  tag_tab [3];
  logic [17:0]  r_tag;
  logic [8:0]   r_idx;
  logic [4:0]   r_off;
  logic [255:0] r_blk;
  int           wait_cnt;

  initial begin
    tag_tab[0] = 18'h00100; tag_tab[1] = 18'h00200; tag_tab[2] = 18'h3FFFF;
    RESET = 1'b0; SYS = 1'b0; dread = 1'b0; dwrite = 1'b0; bwrite = 1'b0;
    dwmode = 2'b00; address = 32'd0; data_in = 32'd0; block_in = 256'd0;
    #1;
    // First reset: pre-reset contents are undefined, so nothing is checked.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 256'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    probe(32'h0000_1234, 1'b0, 1'b0, 32'd0);

    do_fill(32'h0040_0020, mk_blk(32'h1000_0000));
    probe(32'h0040_0020, 1'b1, 1'b0, 32'h1000_0000);
    probe(32'h0040_003C, 1'b1, 1'b0, 32'h1000_0007);
    probe(32'h0080_0020, 1'b0, 1'b0, 32'h1000_0000);

    do_store(32'h0040_0024, 2'b00, 32'hDEAD_BEEF);
    probe(32'h0040_0024, 1'b1, 1'b0, 32'hDEAD_BEEF);
    do_store(32'h0040_0026, 2'b10, 32'h0000_0055);
    probe(32'h0040_0024, 1'b1, 1'b0, 32'hDE55_BEEF);
    do_store(32'h0040_0024, 2'b01, 32'h0000_1234);
    probe(32'h0040_0024, 1'b1, 1'b0, 32'hDE55_1234);
    probe(32'h0080_0020, 1'b0, 1'b1, 32'h1000_0000);

    do_fill(32'h0080_0020, mk_blk(32'h2000_0000));
    probe(32'h0080_0020, 1'b1, 1'b0, 32'h2000_0000);
    probe(32'h0040_0020, 1'b0, 1'b0, 32'h2000_0000);

    do_store(32'h0040_0024, 2'b00, 32'h0000_1111);
    probe(32'h0080_0024, 1'b1, 1'b0, 32'h2000_0001);

    cycle(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 32'h0040_0020, 32'd0, mk_blk(32'h3000_0000),
          1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0080_0024, 32'hAAAA_5555, 256'd0,
          1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    probe(32'h0080_0024, 1'b1, 1'b0, 32'h2000_0001);

    cycle(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 32'h0080_0024, 32'hCAFE_F00D, mk_blk(32'h4000_0000),
          1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    probe(32'h0080_0024, 1'b1, 1'b0, 32'h4000_0001);
    probe(32'h00C0_0020, 1'b0, 1'b0, 32'h4000_0000);
    do_store(32'h0080_0024, 2'b00, 32'hCAFE_F00D);
    probe(32'h0080_0024, 1'b1, 1'b0, 32'hCAFE_F00D);
    probe(32'h00C0_0020, 1'b0, 1'b1, 32'h4000_0000);

    do_reset();
    probe(32'h0080_0024, 1'b0, 1'b0, 32'd0);
    probe(32'h0040_0020, 1'b0, 1'b0, 32'd0);

    // Randomized traffic concentrated on a few indices and tags to force conflicts.
    for (int n = 0; n < 1500; n++) begin
      r_tag = tag_tab[$urandom_range(0, 2)];
      case ($urandom_range(0, 3))
        0:       r_idx = 9'd1;
        1:       r_idx = 9'd2;
        2:       r_idx = 9'h1FF;
        default: r_idx = 9'($urandom_range(0, 511));
      endcase
      r_off = 5'($urandom);
      for (int k = 0; k < 8; k++) r_blk[32*k +: 32] = $urandom;
      cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) < 4), ($urandom_range(0, 99) < 15),
            2'($urandom_range(0, 3)), {r_tag, r_idx, r_off}, $urandom, r_blk,
            1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    end

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(posedge CLK);
      wait_cnt++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_core.md
# dcache_core

Direct-mapped, write-back storage way used as one of the two ways of the set-associative data cache. It holds 2^indx lines of 2^ofst bytes, reports hit and read data combinationally, and merges CPU word, halfword and byte stores into resident lines. It accepts a whole-block fill strobed by the parent controller and exposes the indexed line plus a dirty-victim flag for write-back. Replacement and the miss-penalty counter live in the parent; this block has no FSM of its own.

## Interface
- data, 32, CPU word width.
- addr, 32, byte-address width.
- ofst, 5, block-offset bits (32-byte lines).
- indx, 9, index bits (512 lines).
- Derived: blck = 8<<ofst (256), tag width T = addr-indx-ofst (18), words per line W = 2^(ofst-2).

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RESET  in  1  reset; synchronous, active-low; clock CLK.
- SYS  in  1  system/syscall freeze; when 1, no array update of any kind.
- dread  in  1  CPU load request.
- dwrite  in  1  CPU store request.
- dwmode  in  2  store size: 00 word, 01 halfword, 10 byte, 11 word.
- bread  out  1  dirty-victim flag: indexed line valid, dirty, tag mismatch.
- bwrite  in  1  fill strobe: load block_in into the indexed line.
- address  in  addr  byte address: tag [addr-1:indx+ofst], index [indx+ofst-1:ofst], word [ofst-1:2], byte [1:0].
- data_in  in  data  store data, right-aligned (byte in [7:0], half in [15:0]).
- block_in  in  blck  fill block; word k in bits [32k+31:32k].
- block_out  out  blck  full indexed line, combinational.
- data_out  out  data  indexed word of indexed line, combinational.
- hit  out  1  valid[index] & (tag[index] == address tag), combinational.

## Operation
- State per line: valid bit, dirty bit, T-bit tag, blck-bit data.
- Lookup is purely combinational from address: hit, data_out, block_out and bread. These do not depend on dread or dwrite.
- data_out = line[index] bits [32w+31:32w], w = address[ofst-1:2].
- bread = valid & dirty & ~tagmatch at the current index. The parent samples block_out for write-back while it is high.
- Store (posedge, RESET=1, SYS=0, dwrite=1, hit=1, bwrite=0): merge into word w, then set dirty.
  - Word mode: replace all 32 bits.
  - Halfword mode: lane = address[1]; data_in[15:0] goes to bits [16*lane+15:16*lane].
  - Byte mode: lane = address[1:0]; data_in[7:0] goes to bits [8*lane+7:8*lane].
  - Little-endian lanes; untouched bytes are preserved.
- Store miss (hit=0): no change. The parent fills first and the store then retries as a hit.
- Fill (posedge, RESET=1, SYS=0, bwrite=1): at the index, data←block_in, tag←address tag, valid←1, dirty←0. This happens regardless of hit, dread or dwrite.
- Fill and store in the same cycle: fill wins and the store is dropped. The store then hits on the following cycle.
- dread causes no state change.
- SYS=1: all stores and fills are ignored, and outputs keep tracking address.
- Reset (RESET=0 at posedge): clear all valid, dirty, tag and data to 0. Reset has priority over fill and store in that cycle.

## Timing
- Zero-latency read: hit, data_out, block_out and bread are valid in the same cycle address settles.
- Updates are visible on outputs immediately after the updating posedge.
- Outputs after reset: hit=0, bread=0, data_out=0, block_out=0 for every address.
- Reset asserted mid-miss (during parent penalty) discards the pending line. A later fill behaves normally.
- Reset, fill and store are all synchronous. There are no combinational paths from bwrite, dwrite or data_in to outputs, except through the registered arrays.
- No handshake; the parent guarantees address is stable from request until hit.

## Test plan
- Reset then probe: RESET=0 for one edge, then read address 0x0000_1234 → hit=0, bread=0, data_out=0, block_out=0.
- Fill and read:
  - Stimulus: address 0x0040_0020, block_in with word k = 0x1000_0000+k, bwrite pulse.
  - Response: hit=1; data_out=0x1000_0000; address 0x0040_003C → 0x1000_0007.
  - Address 0x0080_0020 (same index, new tag) → hit=0, bread=0.
- Store modes on hit, filled line, word 1 initially 0x1000_0001:
  - Word store 0xDEADBEEF at 0x0040_0024 → data_out=0xDEADBEEF.
  - Then byte 0x55 at 0x0040_0026 → 0xDE55BEEF.
  - Then halfword 0x1234 at 0x0040_0024 → 0xDE551234.
- Dirty victim after any store: address 0x0080_0020 → hit=0, bread=1, block_out equals the modified line.
  - Fill with new tag → bread=0, hit=1, dirty cleared.
- Miss store and SYS freeze:
  - dwrite on a miss → no line changes.
  - SYS=1 with bwrite or dwrite asserted → contents unchanged, hit unchanged.
- Fill and store in the same cycle → block_in contents kept, store value absent, dirty=0.
